core_regfile: RTL and testbench

- Architectural integer register file with an in-flight write scoreboard.
- Its write port is the far end of the writeback stage's rd_addr_o/data_o pair.
- Two combinational read ports serve decode, with same-cycle writeback bypass.
- Per-register pending-write counters let decode detect RAW/WAW hazards and stall issue.

---
 rtl/core_regfile_if.sv | 38 +++
 rtl/core_regfile.sv | 98 +++++++++
 tb/tb_core_regfile.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_regfile_if.sv
// Bundle between the writeback/decode stages and the register file.
// Handshake: wb_valid_i and iss_valid_i are single-cycle qualifiers with no
// ready on the writeback side; an issue only takes effect when hazard_o is
// low in the same cycle, so hazard_o acts as the inverse of ready for issue.
interface core_regfile_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            wb_valid_i;
   logic [AW-1:0]   wb_rd_addr_i;
   logic [XLEN-1:0] wb_data_i;
   logic [AW-1:0]   rs1_addr_i;
   logic [AW-1:0]   rs2_addr_i;
   logic            rs1_used_i;
   logic            rs2_used_i;
   logic            iss_valid_i;
   logic [AW-1:0]   iss_rd_addr_i;
   logic [XLEN-1:0] rs1_data_o;
   logic [XLEN-1:0] rs2_data_o;
   logic            hazard_o;
   logic            underflow_err_o;

   // Pipeline side: writeback and decode drive requests, observe results.
   modport master (
      output wb_valid_i, wb_rd_addr_i, wb_data_i,
      output rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
      output iss_valid_i, iss_rd_addr_i,
      input  rs1_data_o, rs2_data_o, hazard_o, underflow_err_o
   );

   // Register file side.
   modport slave (
      input  wb_valid_i, wb_rd_addr_i, wb_data_i,
      input  rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
      input  iss_valid_i, iss_rd_addr_i,
      output rs1_data_o, rs2_data_o, hazard_o, underflow_err_o
   );
endinterface

// File: rtl/core_regfile.sv
// Integer register file with writeback bypass and a per-register pending-write
// scoreboard used by decode to stall on RAW/WAW hazards. x0 is hardwired to 0
// and never participates in the scoreboard.
module core_regfile #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int PEND_W = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input logic           clk_i,
   input logic           arst_ni,
   core_regfile_if.slave bus
);

   localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

   logic [XLEN-1:0]   regs_q [NREGS];
   logic [PEND_W-1:0] cnt_q  [NREGS];
   logic              err_q;

   logic              wb_write;
   logic              dec_rs1, dec_rs2, dec_iss;
   logic              hazard;
   logic [NREGS-1:0]  inc_v, dec_v;
   logic              underflow;

   assign wb_write = bus.wb_valid_i && (bus.wb_rd_addr_i != '0);

   // Read ports: x0 reads 0, a same-cycle retiring write is bypassed.
   always_comb begin
      bus.rs1_data_o = '0;
      bus.rs2_data_o = '0;
      if (bus.rs1_addr_i != '0)
         bus.rs1_data_o = (wb_write && bus.wb_rd_addr_i == bus.rs1_addr_i)
                          ? bus.wb_data_i : regs_q[bus.rs1_addr_i];
      if (bus.rs2_addr_i != '0)
         bus.rs2_data_o = (wb_write && bus.wb_rd_addr_i == bus.rs2_addr_i)
                          ? bus.wb_data_i : regs_q[bus.rs2_addr_i];
   end

   // Hazard: a source is busy if writes remain pending after forwarding the
   // retiring one; a destination is blocked if its counter would overflow.
   // Only the current counters feed this, never the issue's own increment.
   always_comb begin
      dec_rs1 = wb_write && bus.wb_rd_addr_i == bus.rs1_addr_i;
      dec_rs2 = wb_write && bus.wb_rd_addr_i == bus.rs2_addr_i;
      dec_iss = wb_write && bus.wb_rd_addr_i == bus.iss_rd_addr_i;
      hazard  = 1'b0;
      if (bus.rs1_used_i && bus.rs1_addr_i != '0 &&
          cnt_q[bus.rs1_addr_i] > PEND_W'(dec_rs1))
         hazard = 1'b1;
      if (bus.rs2_used_i && bus.rs2_addr_i != '0 &&
          cnt_q[bus.rs2_addr_i] > PEND_W'(dec_rs2))
         hazard = 1'b1;
      if (bus.iss_valid_i && bus.iss_rd_addr_i != '0 &&
          cnt_q[bus.iss_rd_addr_i] == CNT_MAX && !dec_iss)
         hazard = 1'b1;
   end

   assign bus.hazard_o        = hazard;
   assign bus.underflow_err_o = err_q;

   // Per-register increment/decrement requests and underflow detection.
   always_comb begin
      inc_v     = '0;
      dec_v     = '0;
      underflow = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         inc_v[r] = bus.iss_valid_i && !hazard && bus.iss_rd_addr_i == AW'(r);
         dec_v[r] = bus.wb_valid_i && bus.wb_rd_addr_i == AW'(r);
         if (dec_v[r] && !inc_v[r] && cnt_q[r] == '0)
            underflow = 1'b1;
      end
   end

   // State: register array, pending counters and the sticky underflow flag.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         if (wb_write)
            regs_q[bus.wb_rd_addr_i] <= bus.wb_data_i;
         for (int r = 1; r < NREGS; r++) begin
            if (inc_v[r] && !dec_v[r])
               cnt_q[r] <= cnt_q[r] + 1'b1;
            else if (dec_v[r] && !inc_v[r] && cnt_q[r] != '0)
               cnt_q[r] <= cnt_q[r] - 1'b1;
         end
         if (underflow)
            err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_core_regfile.sv
// Bench for core_regfile: directed scenarios followed by random traffic, all
// checked against a behavioural model of registers, pending counts and error.
module tb_core_regfile;

   localparam int XLEN = 32;
   localparam int NR   = 32;
   localparam int CMAX = 3;

   logic clk_i = 1'b0;
   logic arst_ni = 1'b0;

   core_regfile_if #(.XLEN(XLEN), .AW(5)) bus ();

   core_regfile #(.XLEN(XLEN), .NREGS(NR), .PEND_W(2)) dut (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .bus     (bus)
   );

   // Clock and reset
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   logic [XLEN-1:0] m_regs [NR];
   int              m_cnt  [NR];
   bit              m_err;

   task automatic check(input string tag, input logic [XLEN-1:0] obs,
                        input logic [XLEN-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < NR; r++) begin
         m_regs[r] = '0;
         m_cnt[r]  = 0;
      end
      m_err = 1'b0;
   endtask

   function automatic logic [XLEN-1:0] model_read(input logic [4:0] a);
      if (a == 0) return '0;
      if (bus.wb_valid_i && bus.wb_rd_addr_i == a) return bus.wb_data_i;
      return m_regs[a];
   endfunction

   // Pending writes left on r once a retiring write this cycle is counted.
   function automatic int model_eff(input logic [4:0] r);
      int e;
      e = m_cnt[r];
      if (bus.wb_valid_i && bus.wb_rd_addr_i == r) e = e - 1;
      return (e < 0) ? 0 : e;
   endfunction

   function automatic bit model_hazard();
      bit h;
      h = 1'b0;
      if (bus.rs1_used_i && bus.rs1_addr_i != 0 && model_eff(bus.rs1_addr_i) > 0) h = 1'b1;
      if (bus.rs2_used_i && bus.rs2_addr_i != 0 && model_eff(bus.rs2_addr_i) > 0) h = 1'b1;
      if (bus.iss_valid_i && bus.iss_rd_addr_i != 0 && m_cnt[bus.iss_rd_addr_i] == CMAX &&
          !(bus.wb_valid_i && bus.wb_rd_addr_i == bus.iss_rd_addr_i)) h = 1'b1;
      return h;
   endfunction

   // Driver: set all inputs for one cycle (applied after negedge).
   task automatic drive(input bit wv, input logic [4:0] wrd, input logic [XLEN-1:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2, input bit u1,
                        input bit u2, input bit iv, input logic [4:0] ird);
      bus.wb_valid_i    = wv;
      bus.wb_rd_addr_i  = wrd;
      bus.wb_data_i     = wd;
      bus.rs1_addr_i    = r1;
      bus.rs2_addr_i    = r2;
      bus.rs1_used_i    = u1;
      bus.rs2_used_i    = u2;
      bus.iss_valid_i   = iv;
      bus.iss_rd_addr_i = ird;
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic check_outputs();
      check("rs1_data", bus.rs1_data_o, model_read(bus.rs1_addr_i));
      check("rs2_data", bus.rs2_data_o, model_read(bus.rs2_addr_i));
      check("hazard", XLEN'(bus.hazard_o), XLEN'(model_hazard()));
      check("underflow", XLEN'(bus.underflow_err_o), XLEN'(m_err));
   endtask

   // Advance one clock and apply the scoreboard rules to the model.
   task automatic tick();
      bit h;
      h = model_hazard();
      @(posedge clk_i);
      if (arst_ni) begin
         if (bus.wb_valid_i && bus.wb_rd_addr_i != 0)
            m_regs[bus.wb_rd_addr_i] = bus.wb_data_i;
         for (int r = 1; r < NR; r++) begin
            bit inc, dec;
            inc = bus.iss_valid_i && !h && bus.iss_rd_addr_i == r;
            dec = bus.wb_valid_i && bus.wb_rd_addr_i == r;
            if (inc && !dec) m_cnt[r]++;
            else if (dec && !inc) begin
               if (m_cnt[r] > 0) m_cnt[r]--;
               else m_err = 1'b1;
            end
         end
      end
      @(negedge clk_i);
   endtask

   task automatic cyc(input bit wv, input logic [4:0] wrd, input logic [XLEN-1:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input bit u1,
                      input bit u2, input bit iv, input logic [4:0] ird);
      drive(wv, wrd, wd, r1, r2, u1, u2, iv, ird);
      check_outputs();
      tick();
   endtask

   initial begin
      model_clear();
      idle();
      repeat (2) @(negedge clk_i);
      arst_ni = 1'b1;
      @(negedge clk_i);

      // Reset state
      drive(1'b0, 5'd0, '0, 5'd5, 5'd31, 1'b1, 1'b1, 1'b0, 5'd0);
      check("rst_rs1", bus.rs1_data_o, 32'h0);
      check("rst_rs2", bus.rs2_data_o, 32'h0);
      check("rst_hazard", XLEN'(bus.hazard_o), 32'h0);
      check("rst_err", XLEN'(bus.underflow_err_o), 32'h0);
      tick();

      // Bypass then array read (retire on x3 underflows; error is sticky)
      drive(1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      check("bypass", bus.rs1_data_o, 32'hDEADBEEF);
      check_outputs();
      tick();
      drive(1'b0, 5'd3, 32'h0BAD0BAD, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0);
      check("array_rd", bus.rs1_data_o, 32'hDEADBEEF);
      check("same_rs", bus.rs2_data_o, 32'hDEADBEEF);
      tick();

      // Clear the error from the x3 retire before scoreboard tests
      arst_ni = 1'b0;
      #1 model_clear();
      @(negedge clk_i);
      arst_ni = 1'b1;

      // x0 writes and issues are ignored
      cyc(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0);
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0);
      check("x0_read", bus.rs1_data_o, 32'h0);
      check("x0_nohaz", XLEN'(bus.hazard_o), 32'h0);
      tick();

      // RAW on x7 with forwarding retire
      cyc(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7);
      drive(1'b0, 5'd0, '0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0);
      check("raw_haz", XLEN'(bus.hazard_o), 32'h1);
      drive(1'b1, 5'd7, 32'h55, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0);
      check("raw_fwd_haz", XLEN'(bus.hazard_o), 32'h0);
      check("raw_fwd_data", bus.rs2_data_o, 32'h55);
      tick();
      drive(1'b0, 5'd0, '0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0);
      check("cnt7_zero", XLEN'(bus.hazard_o), 32'h0);
      tick();

      // Counter saturation on x9
      for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
      check("full_haz", XLEN'(bus.hazard_o), 32'h1);
      tick();
      drive(1'b1, 5'd9, 32'h99, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
      check("full_fwd_haz", XLEN'(bus.hazard_o), 32'h0);
      tick();
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
      check("still_full", XLEN'(bus.hazard_o), 32'h1);
      tick();
      for (int i = 0; i < 3; i++) cyc(1'b1, 5'd9, 32'(i), 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
      check("no_err_yet", XLEN'(bus.underflow_err_o), 32'h0);

      // Underflow on x4, sticky
      cyc(1'b1, 5'd4, 32'h44, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         idle();
         check("err_sticky", XLEN'(bus.underflow_err_o), 32'h1);
         tick();
      end

      // Mid-operation reset with a write held across the reset edge
      cyc(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12);
      drive(1'b1, 5'd12, 32'hCAFEF00D, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13);
      arst_ni = 1'b0;
      #1 model_clear();
      @(posedge clk_i);
      @(negedge clk_i);
      arst_ni = 1'b1;
      drive(1'b0, 5'd0, '0, 5'd12, 5'd4, 1'b1, 1'b1, 1'b1, 5'd13);
      check("rst_reg12", bus.rs1_data_o, 32'h0);
      check("rst_reg4", bus.rs2_data_o, 32'h0);
      check("rst_haz", XLEN'(bus.hazard_o), 32'h0);
      check("rst_err_clr", XLEN'(bus.underflow_err_o), 32'h0);
      tick();

      // Random traffic on a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         logic [4:0] wrd, r1, r2, ird;
         wrd = 5'($urandom_range(0, 6));
         r1  = 5'($urandom_range(0, 6));
         r2  = 5'($urandom_range(0, 6));
         ird = 5'($urandom_range(0, 6));
         cyc(1'($urandom_range(0, 2) == 0), wrd, $urandom, r1, r2,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 2) != 0), ird);
         if (i == 200) begin
            arst_ni = 1'b0;
            #1 model_clear();
            @(negedge clk_i);
            arst_ni = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
